ball_motion: RTL

//   Per-frame ball position/velocity engine; drives the x/y inputs of the ball painter.

---
 rtl/ball_motion.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/ball_motion.sv
// Ball position/velocity engine: latches edge hits per frame, applies bounce+step at frame_tick (BALL_SPEEDUP_EN adds bounce-driven speedup).
// Latency: outputs registered, updated the cycle after frame_tick.
// Backpressure: none; frame_tick is a free-running strobe and is never stalled.
module ball_motion #(
  parameter int SPEED   = 2,
  parameter int X_MIN   = 4,
  parameter int X_MAX   = 635,
  parameter int Y_MIN   = 4,
  parameter int Y_LOST  = 477,
  parameter int REST_Y  = 440,
  parameter int START_X = 320
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       hit_top,
  input  logic       hit_bottom,
  input  logic       hit_left,
  input  logic       hit_right,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       dir_x,
  output logic       dir_y,
  output logic       moving,
  output logic       lost
);

  typedef enum logic [1:0] {IDLE, MOVE, LOST} state_t;

  localparam logic [9:0]         X_MIN_U   = 10'(X_MIN);
  localparam logic [9:0]         X_MAX_U   = 10'(X_MAX);
  localparam logic [8:0]         Y_MIN_U   = 9'(Y_MIN);
  localparam logic [8:0]         REST_Y_U  = 9'(REST_Y);
  localparam logic [9:0]         START_X_U = 10'(START_X);
  localparam logic [2:0]         SPEED_U   = 3'(SPEED);
  localparam logic signed [11:0] X_MIN_S   = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S   = 12'(X_MAX);
  localparam logic signed [10:0] Y_MIN_S   = 11'(Y_MIN);
  localparam logic signed [10:0] Y_LOST_S  = 11'(Y_LOST);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, park_x;
  logic [8:0] y_q, y_d;
  logic       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       lost_q, lost_d;
  logic [2:0] speed_q, speed_d;
  logic       hit_t_q, hit_b_q, hit_l_q, hit_r_q;
  logic       ndx, ndy;
  logic signed [11:0] nx;
  logic signed [10:0] ny;
`ifdef BALL_SPEEDUP_EN
  logic [2:0] bounce_q, bounce_d;
`endif

  // A hit seen in the tick cycle itself belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_t_q <= 1'b0;
      hit_b_q <= 1'b0;
      hit_l_q <= 1'b0;
      hit_r_q <= 1'b0;
    end else if (frame_tick) begin
      hit_t_q <= hit_top;
      hit_b_q <= hit_bottom;
      hit_l_q <= hit_left;
      hit_r_q <= hit_right;
    end else begin
      hit_t_q <= hit_t_q | hit_top;
      hit_b_q <= hit_b_q | hit_bottom;
      hit_l_q <= hit_l_q | hit_left;
      hit_r_q <= hit_r_q | hit_right;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= START_X_U;
      y_q     <= REST_Y_U;
      dir_x_q <= 1'b1;
      dir_y_q <= 1'b0;
      lost_q  <= 1'b0;
      speed_q <= SPEED_U;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      lost_q  <= lost_d;
      speed_q <= speed_d;
    end
  end

`ifdef BALL_SPEEDUP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bounce_q <= 3'd0;
    else        bounce_q <= bounce_d;
  end
`endif

  always_comb begin
    if (paddle_x < X_MIN_U)      park_x = X_MIN_U;
    else if (paddle_x > X_MAX_U) park_x = X_MAX_U;
    else                         park_x = paddle_x;
  end

  // Candidate MOVE update: reflect on latched hits, then screen bounds override, then step.
  always_comb begin
    ndx = dir_x_q;
    ndy = dir_y_q;
    if (hit_l_q && hit_r_q) ndx = ~dir_x_q;
    else if (hit_l_q)       ndx = 1'b1;
    else if (hit_r_q)       ndx = 1'b0;
    if (hit_t_q && hit_b_q) ndy = ~dir_y_q;
    else if (hit_t_q)       ndy = 1'b1;
    else if (hit_b_q)       ndy = 1'b0;
    if (x_q <= X_MIN_U)      ndx = 1'b1;
    else if (x_q >= X_MAX_U) ndx = 1'b0;
    if (y_q <= Y_MIN_U)      ndy = 1'b1;

    nx = ndx ? $signed({2'b00, x_q}) + $signed({9'd0, speed_q})
             : $signed({2'b00, x_q}) - $signed({9'd0, speed_q});
    ny = ndy ? $signed({2'b00, y_q}) + $signed({8'd0, speed_q})
             : $signed({2'b00, y_q}) - $signed({8'd0, speed_q});
    if (nx < X_MIN_S)      nx = X_MIN_S;
    else if (nx > X_MAX_S) nx = X_MAX_S;
    if (ny < Y_MIN_S)      ny = Y_MIN_S;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    lost_d  = 1'b0;
    speed_d = speed_q;
`ifdef BALL_SPEEDUP_EN
    bounce_d = bounce_q;
`endif
    if (frame_tick) begin
      case (state_q)
        IDLE: begin
          x_d = park_x;
          y_d = REST_Y_U;
          if (launch) begin
            state_d = MOVE;
            dir_x_d = 1'b1;
            dir_y_d = 1'b0;
          end
        end
        MOVE: begin
          dir_x_d = ndx;
          dir_y_d = ndy;
          x_d     = nx[9:0];
          y_d     = ny[8:0];
          if (ny >= Y_LOST_S) begin
            state_d = LOST;
            lost_d  = 1'b1;
          end
`ifdef BALL_SPEEDUP_EN
          if (hit_b_q) begin
            bounce_d = bounce_q + 3'd1;
            if (bounce_q == 3'd7 && speed_q != 3'd7) speed_d = speed_q + 3'd1;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          x_d     = park_x;
          y_d     = REST_Y_U;
          speed_d = SPEED_U;
`ifdef BALL_SPEEDUP_EN
          bounce_d = 3'd0;
`endif
        end
      endcase
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign dir_x  = dir_x_q;
  assign dir_y  = dir_y_q;
  assign moving = (state_q == MOVE);
  assign lost   = lost_q;

endmodule
